// File: rtl/psw_flag_unit.sv
// NZVC status register with a LIFO PSW save stack for interrupt entry/return.
// Define PSW_COND_EN to add the branch-condition decode (cond/cond_true).
module psw_flag_unit #(
    parameter int W     = 16,
    parameter int DEPTH = 4,
    parameter int SPW   = 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           upd,
    input  logic [2:0]     op_class,
    input  logic [W-1:0]   res,
    input  logic [W-1:0]   res_hi,
    input  logic           shf_cf,
    input  logic           alu_c,
    input  logic           alu_v,
    input  logic           push,
    input  logic           pop,
    output logic [3:0]     flags,
    output logic [SPW-1:0] sp,
    output logic           empty,
    output logic           full,
    output logic           err
`ifdef PSW_COND_EN
    ,
    input  logic [3:0]     cond,
    output logic           cond_true
`endif
);

    localparam logic [2:0] OP_NONE  = 3'b000;
    localparam logic [2:0] OP_CLR   = 3'b001;
    localparam logic [2:0] OP_LOGIC = 3'b010;
    localparam logic [2:0] OP_ARITH = 3'b011;
    localparam logic [2:0] OP_SHIFT = 3'b100;
    localparam logic [2:0] OP_ASL   = 3'b101;
    localparam logic [2:0] OP_MUL   = 3'b110;
    localparam logic [2:0] OP_LOAD  = 3'b111;

    localparam logic [SPW-1:0] SP_FULL = SPW'(DEPTH);

    logic [3:0]     flags_q, flags_d;
    logic [SPW-1:0] sp_q, sp_d;
    logic           err_q, err_d;
    logic [3:0]     stk_q [DEPTH];
    logic [3:0]     top;
    logic           do_push, do_pop;
    logic           n, z, v, c;
    logic           res_zero;

    assign empty    = (sp_q == '0);
    assign full     = (sp_q == SP_FULL);
    assign do_push  = push & ~pop & ~full;
    assign do_pop   = pop & ~push & ~empty;
    assign err_d    = (push & pop) | (push & full) | (pop & empty);
    assign res_zero = (res == '0);

    always_comb begin
        top = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (sp_q == SPW'(i + 1)) top = stk_q[i];
        end
    end

    always_comb begin
        {n, z, v, c} = flags_q;
        if (upd) begin
            case (op_class)
                OP_NONE: ;
                OP_CLR: begin
                    n = 1'b0;
                    z = 1'b1;
                    c = 1'b0;
                end
                OP_LOGIC: begin
                    n = res[W-1];
                    z = res_zero;
                    v = 1'b0;
                end
                OP_ARITH: begin
                    n = res[W-1];
                    z = res_zero;
                    v = alu_v;
                    c = alu_c;
                end
                OP_SHIFT: begin
                    n = res[W-1];
                    z = res_zero;
                    v = 1'b0;
                    c = shf_cf;
                end
                OP_ASL: begin
                    n = res[W-1];
                    z = res_zero;
                    v = res[W-1] ^ res[W-2];
                    c = shf_cf;
                end
                OP_MUL: begin
                    n = res_hi[W-1];
                    z = res_zero & (res_hi == '0);
                end
                OP_LOAD: {n, z, v, c} = res[3:0];
                default: ;
            endcase
        end
        // A successful pop restores the whole PSW, winning over any update.
        flags_d = do_pop ? top : {n, z, v, c};
    end

    always_comb begin
        sp_d = sp_q;
        if (do_push) sp_d = sp_q + 1'b1;
        else if (do_pop) sp_d = sp_q - 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags_q <= '0;
            sp_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            flags_q <= flags_d;
            sp_q    <= sp_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (do_push && sp_q == SPW'(i)) stk_q[i] <= flags_q;
        end
    end

    assign flags = flags_q;
    assign sp    = sp_q;
    assign err   = err_q;

`ifdef PSW_COND_EN
    logic fn, fz, fv, fc;
    assign {fn, fz, fv, fc} = flags_q;

    always_comb begin
        cond_true = 1'b0;
        case (cond)
            4'd0:  cond_true = 1'b1;
            4'd1:  cond_true = fz;
            4'd2:  cond_true = ~fz;
            4'd3:  cond_true = fc;
            4'd4:  cond_true = ~fc;
            4'd5:  cond_true = fn;
            4'd6:  cond_true = ~fn;
            4'd7:  cond_true = fv;
            4'd8:  cond_true = ~fv;
            4'd9:  cond_true = fc & ~fz;
            4'd10: cond_true = ~fc | fz;
            4'd11: cond_true = (fn == fv);
            4'd12: cond_true = (fn != fv);
            4'd13: cond_true = ~fz & (fn == fv);
            4'd14: cond_true = fz | (fn != fv);
            default: cond_true = 1'b0;
        endcase
    end
`endif

endmodule

// File: tb/tb_psw_flag_unit.sv
// Directed self-checking bench for psw_flag_unit (W=16, DEPTH=4, SPW=3).
// Condition-decode checks are compiled only with PSW_COND_EN.
module tb_psw_flag_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        upd;
    logic [2:0]  op_class;
    logic [15:0] res;
    logic [15:0] res_hi;
    logic        shf_cf;
    logic        alu_c;
    logic        alu_v;
    logic        push;
    logic        pop;
    logic [3:0]  flags;
    logic [2:0]  sp;
    logic        empty;
    logic        full;
    logic        err;
`ifdef PSW_COND_EN
    logic [3:0]  cond;
    logic        cond_true;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    psw_flag_unit #(.W(16), .DEPTH(4), .SPW(3)) dut (
        .clk      (clk),
        .rst      (rst),
        .upd      (upd),
        .op_class (op_class),
        .res      (res),
        .res_hi   (res_hi),
        .shf_cf   (shf_cf),
        .alu_c    (alu_c),
        .alu_v    (alu_v),
        .push     (push),
        .pop      (pop),
        .flags    (flags),
        .sp       (sp),
        .empty    (empty),
        .full     (full),
        .err      (err)
`ifdef PSW_COND_EN
        ,
        .cond     (cond),
        .cond_true(cond_true)
`endif
    );

    task automatic chk(input string tag, input logic [7:0] got,
                       input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic [2:0] oc, input logic [15:0] r);
        upd = 1'b1;
        op_class = oc;
        res = r;
    endtask

    initial begin
        rst = 1'b1; upd = 1'b0; op_class = 3'd0; res = '0; res_hi = '0;
        shf_cf = 1'b0; alu_c = 1'b0; alu_v = 1'b0; push = 1'b0; pop = 1'b0;
`ifdef PSW_COND_EN
        cond = 4'd0;
`endif
        #1;
        chk("rst_flags", {4'b0, flags}, 8'h00);
        chk("rst_sp", {5'b0, sp}, 8'd0);
        chk("rst_empty", {7'b0, empty}, 8'd1);
        chk("rst_full", {7'b0, full}, 8'd0);
        chk("rst_err", {7'b0, err}, 8'd0);
        step();
        rst = 1'b0;

        op(3'b011, 16'h8000); alu_c = 1'b1; alu_v = 1'b1;
        step();
        chk("arith", {4'b0, flags}, 8'b1011);
        op(3'b010, 16'h0000);
        step();
        chk("logic_c_kept", {4'b0, flags}, 8'b0101);
        op(3'b101, 16'h4000); shf_cf = 1'b1;
        step();
        chk("asl", {4'b0, flags}, 8'b0011);
        op(3'b110, 16'h0000); res_hi = 16'h8000;
        step();
        chk("mul", {4'b0, flags}, 8'b1011);
        op(3'b000, 16'h0000);
        step();
        chk("none_hold", {4'b0, flags}, 8'b1011);
        upd = 1'b0; op_class = 3'b010;
        step();
        chk("noupd_hold", {4'b0, flags}, 8'b1011);
        op(3'b001, 16'h1234);
        step();
        chk("clr_v_kept", {4'b0, flags}, 8'b0110);
        op(3'b100, 16'h0001); shf_cf = 1'b0;
        step();
        chk("shift", {4'b0, flags}, 8'b0000);
        op(3'b110, 16'h0000); res_hi = 16'h0000;
        step();
        chk("mul_zero", {4'b0, flags}, 8'b0100);

        op(3'b111, 16'h0001);
        step();
        chk("load1", {4'b0, flags}, 8'b0001);
        upd = 1'b0; push = 1'b1;
        step();
        chk("sp1", {5'b0, sp}, 8'd1);
        push = 1'b0; op(3'b111, 16'h0002);
        step();
        chk("load2", {4'b0, flags}, 8'b0010);
        upd = 1'b0; push = 1'b1;
        step();
        chk("sp2", {5'b0, sp}, 8'd2);
        push = 1'b0; pop = 1'b1;
        step();
        chk("pop1_flags", {4'b0, flags}, 8'b0010);
        chk("pop1_sp", {5'b0, sp}, 8'd1);
        step();
        chk("pop2_flags", {4'b0, flags}, 8'b0001);
        chk("pop2_sp", {5'b0, sp}, 8'd0);
        chk("pop2_empty", {7'b0, empty}, 8'd1);
        op(3'b111, 16'h0009);
        step();
        chk("underflow_err", {7'b0, err}, 8'd1);
        chk("underflow_upd", {4'b0, flags}, 8'b1001);
        chk("underflow_sp", {5'b0, sp}, 8'd0);
        pop = 1'b0; upd = 1'b0;
        step();
        chk("err_pulse_end", {7'b0, err}, 8'd0);

        push = 1'b1;
        repeat (4) step();
        chk("fill_sp", {5'b0, sp}, 8'd4);
        chk("fill_full", {7'b0, full}, 8'd1);
        chk("fill_noerr", {7'b0, err}, 8'd0);
        op(3'b111, 16'h0003);
        step();
        chk("overflow_err", {7'b0, err}, 8'd1);
        chk("overflow_sp", {5'b0, sp}, 8'd4);
        chk("overflow_upd", {4'b0, flags}, 8'b0011);
        push = 1'b0; upd = 1'b0; pop = 1'b1;
        step();
        chk("lifo_top", {4'b0, flags}, 8'b1001);
        pop = 1'b0;

        op(3'b111, 16'h000f);
        step();
        upd = 1'b0; push = 1'b1;
        step();
        push = 1'b0;
        chk("pre_rst_sp", {5'b0, sp}, 8'd4);
        chk("pre_rst_flags", {4'b0, flags}, 8'b1111);
        #3 rst = 1'b1;
        #1;
        chk("async_flags", {4'b0, flags}, 8'h00);
        chk("async_sp", {5'b0, sp}, 8'd0);
        chk("async_empty", {7'b0, empty}, 8'd1);
        #1 rst = 1'b0;

        op(3'b111, 16'h000a);
        step();
        push = 1'b1; op(3'b001, 16'h0000);
        step();
        chk("push_clr_flags", {4'b0, flags}, 8'b0110);
        chk("push_clr_sp", {5'b0, sp}, 8'd1);
        push = 1'b0; pop = 1'b1; op(3'b111, 16'h000f);
        step();
        chk("pop_wins", {4'b0, flags}, 8'b1010);
        chk("pop_wins_sp", {5'b0, sp}, 8'd0);
        push = 1'b1; op(3'b111, 16'h0005);
        step();
        chk("pushpop_err", {7'b0, err}, 8'd1);
        chk("pushpop_sp", {5'b0, sp}, 8'd0);
        chk("pushpop_upd", {4'b0, flags}, 8'b0101);
        push = 1'b0; pop = 1'b0; upd = 1'b0;

`ifdef PSW_COND_EN
        op(3'b111, 16'h0008);
        step();
        upd = 1'b0;
        cond = 4'd11; #1;
        chk("cond11", {7'b0, cond_true}, 8'd0);
        cond = 4'd12; #1;
        chk("cond12", {7'b0, cond_true}, 8'd1);
        cond = 4'd13; #1;
        chk("cond13_n", {7'b0, cond_true}, 8'd0);
        op(3'b111, 16'h0000);
        step();
        upd = 1'b0;
        cond = 4'd13; #1;
        chk("cond13_z", {7'b0, cond_true}, 8'd1);
        cond = 4'd15; #1;
        chk("cond15", {7'b0, cond_true}, 8'd0);
        cond = 4'd0; #1;
        chk("cond0", {7'b0, cond_true}, 8'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
